gen_fifo_rd_dwc: RTL and testbench

- Read-side data-width down-converter that sits directly downstream of the zero-delay generic FIFO.
- Watches the FIFO's output data and empty status, and pops one wide word at a time.
- Serialises each word into narrow beats on a valid/ready output port.
- Zero-bubble: a word being popped and the previous word's last beat leave in the same cycle, so word-to-word streaming has no idle gap.

---
 rtl/gen_fifo_dwc_pkg.sv | 19 +
 rtl/gen_fifo_rd_dwc_if.sv | 23 ++
 rtl/gen_fifo_rd_dwc.sv | 92 +++++++++
 tb/tb_gen_fifo_rd_dwc.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gen_fifo_dwc_pkg.sv
// Shared types and helpers for the FIFO read-side data-width down-converter.
package gen_fifo_dwc_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } dwc_state_e;

    // A zero or oversized request means "send the whole word".
    function automatic int eff_beats(input int cfg, input int ratio);
        return (cfg == 0 || cfg > ratio) ? ratio : cfg;
    endfunction

    function automatic int beat_lsb(input int idx, input int ratio, input int out_w,
                                    input int lsb_first);
        return (lsb_first != 0) ? idx * out_w : (ratio - 1 - idx) * out_w;
    endfunction

endpackage

// File: rtl/gen_fifo_rd_dwc_if.sv
// FIFO-facing and beat-stream handshake signals of the read-side down-converter.
interface gen_fifo_rd_dwc_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 4
);
    logic [IN_W-1:0]  fifo_dat;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [OUT_W-1:0] out_dat;
    logic             out_vld;
    logic             out_rdy;
    logic             out_last;

    modport master (
        input  fifo_dat, fifo_empty, out_rdy,
        output fifo_pop, out_dat, out_vld, out_last
    );

    modport slave (
        output fifo_dat, fifo_empty, out_rdy,
        input  fifo_pop, out_dat, out_vld, out_last
    );
endinterface

// File: rtl/gen_fifo_rd_dwc.sv
// Pops wide words from a zero-delay FIFO and serialises them into narrow beats,
// loading the next word on the same edge the previous word's last beat leaves.
module gen_fifo_rd_dwc
    import gen_fifo_dwc_pkg::*;
#(
    parameter  int IN_W      = 16,
    parameter  int OUT_W     = 4,
    parameter  int LSB_FIRST = 1,
    localparam int RATIO     = IN_W / OUT_W,
    localparam int BCNT_W    = $clog2(RATIO) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BCNT_W-1:0] cfg_beats,
    input  logic              flush,
    gen_fifo_rd_dwc_if.master bus,
    output logic              sts_busy,
    output logic [15:0]       sts_words,
    output logic              err_drop
);

    dwc_state_e        state_q, state_d;
    logic [IN_W-1:0]   hold_q, hold_d;
    logic [BCNT_W-1:0] idx_q, idx_d;
    logic [BCNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]       words_q, words_d;
    logic              err_q, err_d;

    logic vld, last, xfer, last_xfer, load;

    always_comb begin
        vld       = (state_q == SEND);
        last      = vld && (idx_q == cnt_q - BCNT_W'(1));
        xfer      = vld && bus.out_rdy;
        last_xfer = xfer && last;
        load      = !rst && !bus.fifo_empty && !flush && (!vld || last_xfer);
    end

    // Load wins over everything else; it can only coincide with a last-beat transfer.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        words_d = words_q;
        err_d   = 1'b0;
        if (last_xfer) begin
            words_d = words_q + 16'd1;
        end
        if (load) begin
            state_d = SEND;
            hold_d  = bus.fifo_dat;
            idx_d   = '0;
            cnt_d   = BCNT_W'(eff_beats(32'(cfg_beats), RATIO));
        end else if (flush && vld) begin
            state_d = IDLE;
            err_d   = !last_xfer;
        end else if (last_xfer) begin
            state_d = IDLE;
        end else if (xfer) begin
            idx_d = idx_q + BCNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            words_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            words_q <= words_d;
            err_q   <= err_d;
        end
    end

    assign bus.fifo_pop = load;
    assign bus.out_vld  = vld;
    assign bus.out_last = last;
    assign bus.out_dat  = vld ? OUT_W'(hold_q >> beat_lsb(32'(idx_q), RATIO, OUT_W, LSB_FIRST))
                              : '0;
    assign sts_busy     = vld;
    assign sts_words    = words_q;
    assign err_drop     = err_q;

endmodule

// File: tb/tb_gen_fifo_rd_dwc.sv
// Scoreboard bench: two converters (LSB-first and MSB-first) share one FIFO model
// and are checked every cycle against a queue of expected beats.
module tb_gen_fifo_rd_dwc;

    localparam int IN_W   = 16;
    localparam int OUT_W  = 4;
    localparam int RATIO  = IN_W / OUT_W;
    localparam int BCNT_W = $clog2(RATIO) + 1;

    typedef struct {
        logic [15:0] dat;
        logic [2:0]  cfg;
    } fifo_ent_t;

    typedef struct {
        logic [3:0] lsb;
        logic [3:0] msb;
        bit         last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic [BCNT_W-1:0] cfg_beats = '0;
    logic              busy_l, busy_m, err_l, err_m;
    logic [15:0]       words_l, words_m;

    fifo_ent_t fifo_q[$];
    beat_t     exp_q[$];
    bit        active = 1'b0;
    int        words_exp = 0;
    bit        err_exp = 1'b0;
    int        n_checks = 0;
    int        n_fail = 0;

    gen_fifo_rd_dwc_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus_l ();
    gen_fifo_rd_dwc_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus_m ();

    gen_fifo_rd_dwc #(.IN_W(IN_W), .OUT_W(OUT_W), .LSB_FIRST(1)) u_dut_lsb (
        .clk(clk), .rst(rst), .cfg_beats(cfg_beats), .flush(flush), .bus(bus_l),
        .sts_busy(busy_l), .sts_words(words_l), .err_drop(err_l)
    );

    gen_fifo_rd_dwc #(.IN_W(IN_W), .OUT_W(OUT_W), .LSB_FIRST(0)) u_dut_msb (
        .clk(clk), .rst(rst), .cfg_beats(cfg_beats), .flush(flush), .bus(bus_m),
        .sts_busy(busy_m), .sts_words(words_m), .err_drop(err_m)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        logic [15:0] d;
        logic [2:0]  c;
        d = 16'($urandom);
        c = 3'($urandom);
        if (fifo_q.size() > 0) begin
            d = fifo_q[0].dat;
            c = fifo_q[0].cfg;
        end
        bus_l.fifo_empty = (fifo_q.size() == 0);
        bus_m.fifo_empty = (fifo_q.size() == 0);
        bus_l.fifo_dat   = d;
        bus_m.fifo_dat   = d;
        cfg_beats        = c;
    endtask

    // The beat count travels with its word, so the expected beats are known on issue.
    task automatic applyStimulus(input logic [15:0] dat, input logic [2:0] cfg);
        int    eff;
        beat_t b;
        eff = (cfg == 0 || int'(cfg) > RATIO) ? RATIO : int'(cfg);
        fifo_q.push_back('{dat, cfg});
        for (int i = 0; i < eff; i++) begin
            b.lsb  = 4'(dat >> (4 * i));
            b.msb  = 4'(dat >> (4 * (RATIO - 1 - i)));
            b.last = (i == eff - 1);
            exp_q.push_back(b);
        end
        drive_fifo();
    endtask

    task automatic set_rdy(input bit r);
        bus_l.out_rdy = r;
        bus_m.out_rdy = r;
    endtask

    task automatic step();
        logic popped;
        @(negedge clk);
        popped = bus_l.fifo_pop;
        @(posedge clk);
        #1;
        if (popped && fifo_q.size() > 0) void'(fifo_q.pop_front());
        drive_fifo();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((fifo_q.size() > 0 || active) && n < budget) begin
            step();
            n++;
        end
        checkOutput("drain_timeout", 32'(fifo_q.size() > 0 || active), 32'd0);
        step();
    endtask

    task automatic drop_current();
        beat_t b;
        while (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            if (b.last) break;
        end
    endtask

    initial begin : monitor
        bit   xfer, lastx;
        logic exp_pop;
        forever begin
            @(negedge clk);
            if (rst) begin
                checkOutput("rst_outs_l", {bus_l.out_vld, bus_l.out_last, bus_l.out_dat,
                            bus_l.fifo_pop, err_l, busy_l, words_l}, 32'd0);
                checkOutput("rst_outs_m", {bus_m.out_vld, bus_m.out_last, bus_m.out_dat,
                            bus_m.fifo_pop, err_m, busy_m, words_m}, 32'd0);
                if (active) drop_current();
                active    = 1'b0;
                words_exp = 0;
                err_exp   = 1'b0;
            end else begin
                checkOutput("vld_l", 32'(bus_l.out_vld), 32'(active));
                checkOutput("vld_m", 32'(bus_m.out_vld), 32'(active));
                checkOutput("busy_l", 32'(busy_l), 32'(active));
                checkOutput("busy_m", 32'(busy_m), 32'(active));
                if (active && exp_q.size() > 0) begin
                    checkOutput("dat_l", 32'(bus_l.out_dat), 32'(exp_q[0].lsb));
                    checkOutput("dat_m", 32'(bus_m.out_dat), 32'(exp_q[0].msb));
                    checkOutput("last_l", 32'(bus_l.out_last), 32'(exp_q[0].last));
                    checkOutput("last_m", 32'(bus_m.out_last), 32'(exp_q[0].last));
                end
                xfer    = active && bus_l.out_rdy;
                lastx   = xfer && exp_q.size() > 0 && exp_q[0].last;
                exp_pop = (fifo_q.size() > 0) && !flush && (!active || lastx);
                checkOutput("pop_l", 32'(bus_l.fifo_pop), 32'(exp_pop));
                checkOutput("pop_m", 32'(bus_m.fifo_pop), 32'(exp_pop));
                checkOutput("words_l", 32'(words_l), 32'(16'(words_exp)));
                checkOutput("words_m", 32'(words_m), 32'(16'(words_exp)));
                checkOutput("err_l", 32'(err_l), 32'(err_exp));
                checkOutput("err_m", 32'(err_m), 32'(err_exp));
                if (xfer && exp_q.size() > 0) void'(exp_q.pop_front());
                if (lastx) words_exp++;
                err_exp = 1'b0;
                if (exp_pop) begin
                    active = 1'b1;
                end else if (flush && active) begin
                    if (!lastx) begin
                        drop_current();
                        err_exp = 1'b1;
                    end
                    active = 1'b0;
                end else if (lastx) begin
                    active = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        n_fail++;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        set_rdy(1'b1);
        drive_fifo();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] single word, default beat count");
        applyStimulus(16'hA5C3, 3'd0);
        wait_idle(50);

        $display("[TB] back-to-back words");
        applyStimulus(16'h1234, 3'd0);
        applyStimulus(16'h5678, 3'd0);
        applyStimulus(16'h9ABC, 3'd0);
        wait_idle(50);

        $display("[TB] backpressure on beat 2");
        applyStimulus(16'h4D2B, 3'd0);
        applyStimulus(16'h7E61, 3'd0);
        repeat (3) step();
        set_rdy(1'b0);
        repeat (5) step();
        set_rdy(1'b1);
        wait_idle(50);

        $display("[TB] truncated words");
        applyStimulus(16'hBEEF, 3'd2);
        applyStimulus(16'h0F1E, 3'd1);
        applyStimulus(16'h3C2D, 3'd1);
        applyStimulus(16'h5A69, 3'd7);
        wait_idle(50);

        $display("[TB] flush on beat 1");
        applyStimulus(16'hCAFE, 3'd0);
        applyStimulus(16'h1357, 3'd0);
        repeat (2) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_idle(50);

        $display("[TB] asynchronous reset during beat 2");
        applyStimulus(16'h2468, 3'd0);
        applyStimulus(16'h8642, 3'd0);
        repeat (3) step();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_l", {bus_l.out_vld, bus_l.out_last, bus_l.out_dat,
                    bus_l.fifo_pop, err_l, busy_l, words_l}, 32'd0);
        checkOutput("async_rst_m", {bus_m.out_vld, bus_m.out_last, bus_m.out_dat,
                    bus_m.fifo_pop, err_m, busy_m, words_m}, 32'd0);
        step();
        rst = 1'b0;
        wait_idle(50);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(2) == 0 && fifo_q.size() < 4)
                applyStimulus(16'($urandom), 3'($urandom));
            set_rdy($urandom_range(3) != 0);
            flush = ($urandom_range(19) == 0);
            step();
        end
        flush = 1'b0;
        set_rdy(1'b1);
        wait_idle(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
